bus_timer: RTL and testbench



---
 rtl/bus_timer.sv | 155 +++++++++++++++
 tb/tb_bus_timer.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/bus_timer.sv
// 16-bit memory-mapped down-counting interval timer with 8-bit prescaler.
// Responds on the 6502 bus at eight register slots and drives an active-low IRQ.
module bus_timer #(
    parameter logic [15:0] RELOAD_RESET   = 16'hFFFF,
    parameter logic [7:0]  PRESCALE_RESET = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cs,
    input  logic [2:0] addr,
    input  logic       rw,
    input  logic [7:0] idata,
    output logic [7:0] odata,
    output logic       irq
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PS_W  = 8;
    localparam int unsigned BUS_W = 8;

    localparam logic [2:0] A_RELOAD_LO = 3'd0;
    localparam logic [2:0] A_RELOAD_HI = 3'd1;
    localparam logic [2:0] A_SNAP_LO   = 3'd2;
    localparam logic [2:0] A_SNAP_HI   = 3'd3;
    localparam logic [2:0] A_CTRL      = 3'd4;
    localparam logic [2:0] A_STATUS    = 3'd5;
    localparam logic [2:0] A_PRESCALE  = 3'd6;

    logic [CNT_W-1:0] reload_q, reload_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] snap_q, snap_d;
    logic [PS_W-1:0]  prescale_q, prescale_d;
    logic [PS_W-1:0]  pcnt_q, pcnt_d;
    logic             en_q, en_d;
    logic             oneshot_q, oneshot_d;
    logic             ien_q, ien_d;
    logic             flag_q, flag_d;

    logic wr_c;
    logic wr_ctrl_c;
    logic start_c;
    logic tick_c;
    logic expire_c;

    // Bus strobes and timebase events, all from pre-edge register state.
    always_comb begin
        wr_c      = cs & ~rw;
        wr_ctrl_c = wr_c & (addr == A_CTRL);
        start_c   = wr_ctrl_c & idata[0] & ~en_q;
        tick_c    = en_q & (pcnt_q == prescale_q);
        expire_c  = tick_c & (count_q == '0);
    end

    // Next-state for every register; writes held over many cycles must be idempotent.
    always_comb begin
        reload_d   = reload_q;
        count_d    = count_q;
        snap_d     = snap_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        en_d       = en_q;
        oneshot_d  = oneshot_q;
        ien_d      = ien_q;
        flag_d     = flag_q;

        if (start_c) begin
            pcnt_d = '0;
        end else if (en_q) begin
            pcnt_d = tick_c ? '0 : pcnt_q + PS_W'(1);
        end

        if (start_c) begin
            count_d = reload_q;
        end else if (tick_c) begin
            if (count_q != '0) begin
                count_d = count_q - CNT_W'(1);
            end else if (oneshot_q) begin
                count_d = '0;
                en_d    = 1'b0;
            end else begin
                count_d = reload_q;
            end
        end

        if (wr_c) begin
            case (addr)
                A_RELOAD_LO: reload_d[7:0]  = idata;
                A_RELOAD_HI: reload_d[15:8] = idata;
                A_SNAP_LO:   snap_d         = count_q;
                A_CTRL: begin
                    // A CPU write to EN overrides a same-edge one-shot expiry.
                    en_d      = idata[0];
                    oneshot_d = idata[1];
                    ien_d     = idata[2];
                end
                A_STATUS: begin
                    if (idata[0]) begin
                        flag_d = 1'b0;
                    end
                end
                A_PRESCALE:  prescale_d = idata;
                default: ;
            endcase
        end

        // Expiry set has priority over a same-edge write-1-to-clear.
        if (expire_c) begin
            flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            reload_q   <= RELOAD_RESET;
            count_q    <= '0;
            snap_q     <= '0;
            prescale_q <= PRESCALE_RESET;
            pcnt_q     <= '0;
            en_q       <= 1'b0;
            oneshot_q  <= 1'b0;
            ien_q      <= 1'b0;
            flag_q     <= 1'b0;
        end else begin
            reload_q   <= reload_d;
            count_q    <= count_d;
            snap_q     <= snap_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            en_q       <= en_d;
            oneshot_q  <= oneshot_d;
            ien_q      <= ien_d;
            flag_q     <= flag_d;
        end
    end

    // Read mux drives zero when not selected so the top level can OR read buses.
    always_comb begin
        odata = '0;
        if (cs && rw) begin
            case (addr)
                A_RELOAD_LO: odata = reload_q[7:0];
                A_RELOAD_HI: odata = reload_q[15:8];
                A_SNAP_LO:   odata = snap_q[7:0];
                A_SNAP_HI:   odata = snap_q[15:8];
                A_CTRL:      odata = BUS_W'({ien_q, oneshot_q, en_q});
                A_STATUS:    odata = BUS_W'({en_q, flag_q});
                A_PRESCALE:  odata = prescale_q;
                default:     odata = '0;
            endcase
        end
    end

    assign irq = ~(flag_q & ien_q);

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: expected read data is queued when a read is
// driven and popped when the combinational read data is sampled.
module tb_bus_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cs;
    logic [2:0] addr;
    logic       rw;
    logic [7:0] idata;
    logic [7:0] odata;
    logic       irq;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    logic [7:0]  exp_q[$];

    bus_timer #(
        .RELOAD_RESET   (16'hFFFF),
        .PRESCALE_RESET (8'h00)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .cs    (cs),
        .addr  (addr),
        .rw    (rw),
        .idata (idata),
        .odata (odata),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic bus_read(input logic [2:0] a, input logic [7:0] exp, input string tag);
        exp_q.push_back(exp);
        cs   = 1'b1;
        rw   = 1'b1;
        addr = a;
        #1;
        check_eq(tag, 16'(odata), 16'(exp_q.pop_front()));
        cs   = 1'b0;
    endtask

    // Waits for the next falling edge, then holds the write for n rising edges.
    task automatic bus_write(input logic [2:0] a, input logic [7:0] d, input int n);
        @(negedge clk);
        cs    = 1'b1;
        rw    = 1'b0;
        addr  = a;
        idata = d;
        repeat (n) @(negedge clk);
        cs    = 1'b0;
        rw    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic got_irq;
        rst = 1'b0; cs = 1'b0; rw = 1'b1; addr = 3'd0; idata = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Reset state
        bus_read(3'd0, 8'hFF, "rst_reload_lo");
        bus_read(3'd1, 8'hFF, "rst_reload_hi");
        bus_read(3'd4, 8'h00, "rst_ctrl");
        bus_read(3'd5, 8'h00, "rst_status");
        bus_read(3'd7, 8'h00, "rst_reserved");
        check_eq("rst_irq", 16'(irq), 16'd1);
        cs = 1'b0; rw = 1'b1; addr = 3'd0; #1;
        check_eq("odata_no_cs", 16'(odata), 16'd0);

        // Periodic RELOAD=3 with IRQ, CTRL held 4 edges
        bus_write(3'd0, 8'h03, 1);
        bus_write(3'd1, 8'h00, 1);
        bus_write(3'd6, 8'h00, 1);
        cs = 1'b1; rw = 1'b0; addr = 3'd4; idata = 8'h05;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq($sformatf("per_irq_hi_e%0d", i), 16'(irq), 16'd1);
        end
        cs = 1'b0; rw = 1'b1;
        @(negedge clk);
        check_eq("per_irq_lo_e4", 16'(irq), 16'd0);
        bus_read(3'd5, 8'h03, "per_status_e4");
        bus_write(3'd5, 8'h01, 1);
        bus_read(3'd5, 8'h02, "per_status_cleared");
        check_eq("per_irq_cleared", 16'(irq), 16'd1);
        @(negedge clk);
        check_eq("per_irq_e7", 16'(irq), 16'd1);
        @(negedge clk);
        check_eq("per_irq_e8", 16'(irq), 16'd0);
        bus_write(3'd4, 8'h00, 1);
        bus_write(3'd5, 8'h01, 1);
        bus_read(3'd5, 8'h00, "per_stopped");

        // One-shot RELOAD=2 PRESCALE=2, no IEN: expiry 9 edges after start
        bus_write(3'd0, 8'h02, 1);
        bus_write(3'd1, 8'h00, 1);
        bus_write(3'd6, 8'h02, 1);
        bus_write(3'd4, 8'h03, 1);
        repeat (8) @(negedge clk);
        bus_read(3'd5, 8'h02, "os_status_e8");
        @(negedge clk);
        bus_read(3'd5, 8'h01, "os_status_e9");
        bus_read(3'd4, 8'h02, "os_ctrl_en_off");
        check_eq("os_irq_high", 16'(irq), 16'd1);
        bus_write(3'd2, 8'h00, 1);
        bus_read(3'd2, 8'h00, "os_count_lo");
        bus_read(3'd3, 8'h00, "os_count_hi");
        bus_write(3'd5, 8'h01, 1);
        bus_write(3'd4, 8'h00, 1);
        bus_read(3'd5, 8'h00, "os_cleared");

        // RELOAD=0: clear on an expiry edge loses to the set
        bus_write(3'd0, 8'h00, 1);
        bus_write(3'd1, 8'h00, 1);
        bus_write(3'd6, 8'h00, 1);
        bus_write(3'd4, 8'h01, 1);
        bus_read(3'd5, 8'h02, "r0_started");
        bus_write(3'd5, 8'h01, 2);
        bus_read(3'd5, 8'h03, "r0_set_wins");
        bus_write(3'd4, 8'h00, 1);
        bus_write(3'd5, 8'h01, 1);

        // Snapshot of a running count; three idle falling edges plus the write's own wait give 4 ticks
        bus_write(3'd0, 8'h34, 1);
        bus_write(3'd1, 8'h12, 1);
        bus_write(3'd4, 8'h01, 1);
        repeat (3) @(negedge clk);
        bus_write(3'd2, 8'hFF, 1);
        bus_read(3'd2, 8'h30, "snap_lo");
        bus_read(3'd3, 8'h12, "snap_hi");
        repeat (5) @(negedge clk);
        bus_read(3'd2, 8'h30, "snap_lo_stable");
        bus_read(3'd3, 8'h12, "snap_hi_stable");
        bus_write(3'd4, 8'h00, 1);

        // Async reset mid-count with IRQ asserted
        bus_write(3'd0, 8'h02, 1);
        bus_write(3'd1, 8'h00, 1);
        bus_write(3'd6, 8'h01, 1);
        bus_write(3'd4, 8'h05, 1);
        got_irq = 1'b0;
        for (int i = 0; i < 30 && !got_irq; i++) begin
            @(negedge clk);
            if (irq == 1'b0) got_irq = 1'b1;
        end
        check_eq("ar_irq_low", 16'(irq), 16'd0);
        #2;
        rst = 1'b0;
        #1;
        check_eq("ar_irq_now", 16'(irq), 16'd1);
        bus_read(3'd0, 8'hFF, "ar_reload_lo");
        bus_read(3'd1, 8'hFF, "ar_reload_hi");
        bus_read(3'd2, 8'h00, "ar_snap_lo");
        bus_read(3'd3, 8'h00, "ar_snap_hi");
        bus_read(3'd4, 8'h00, "ar_ctrl");
        bus_read(3'd5, 8'h00, "ar_status");
        bus_read(3'd6, 8'h00, "ar_prescale");
        cs = 1'b0; #1;
        check_eq("ar_odata_idle", 16'(odata), 16'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (10) @(negedge clk);
        check_eq("ar_no_expiry", 16'(irq), 16'd1);
        bus_read(3'd5, 8'h00, "ar_status_after");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
